// File: rtl/mult_share_arb_pkg.sv
// Shared constants and types for the shared-multiplier arbiter.
//   BITS            fixed-point fraction bits (dequantize shift)
//   DATA_WIDTH_DEF  default signed operand/result width
//   tag_t           requester tag carried through the pipeline (fits N_REQ up to 8)
//   SAT_MAX/SAT_MIN saturation bounds for the default data width
package mult_share_arb_pkg;

   localparam int BITS           = 10;
   localparam int DATA_WIDTH_DEF = 32;
   localparam int TAG_W          = 3;

   typedef logic [TAG_W-1:0] tag_t;

   localparam logic signed [DATA_WIDTH_DEF-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH_DEF-1){1'b1}}};
   localparam logic signed [DATA_WIDTH_DEF-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH_DEF-1){1'b0}}};

endpackage

// File: rtl/mult_share_pipe.sv
// Pipelined signed multiply with dequantizing shift. Stage 1 registers the
// operands, later stages carry the full product; valid and tag travel along.
// The shift and the wrap/saturate step are applied at the output of the last
// stage, so result latency is exactly LATENCY cycles.
// Optional: MULT_SHARE_ARB_SAT_EN saturates instead of wrapping.
// Ports:
//   clock, reset        clock, async active-high reset
//   in_valid/tag/x/y    operand pair entering stage 1
//   out_valid/tag/data  last-stage result
import mult_share_arb_pkg::*;

module mult_share_pipe #(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int LATENCY    = 3,
   parameter int FRAC_BITS  = BITS
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  in_valid,
   input  tag_t                  in_tag,
   input  logic [DATA_WIDTH-1:0] in_x,
   input  logic [DATA_WIDTH-1:0] in_y,
   output logic                  out_valid,
   output tag_t                  out_tag,
   output logic [DATA_WIDTH-1:0] out_data
);

   localparam int PW = 2 * DATA_WIDTH;

   logic                         vld_q [LATENCY];
   tag_t                         tag_q [LATENCY];
   logic signed [DATA_WIDTH-1:0] x_q, y_q;
   logic signed [PW-1:0]         mul_c, prod_last, shifted;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < LATENCY; i++) begin
            vld_q[i] <= 1'b0;
            tag_q[i] <= '0;
         end
         x_q <= '0;
         y_q <= '0;
      end else begin
         vld_q[0] <= in_valid;
         tag_q[0] <= in_tag;
         x_q      <= in_x;
         y_q      <= in_y;
         for (int i = 1; i < LATENCY; i++) begin
            vld_q[i] <= vld_q[i-1];
            tag_q[i] <= tag_q[i-1];
         end
      end
   end

   // both operands signed, so they are sign-extended to the product width
   assign mul_c = x_q * y_q;

   generate
      if (LATENCY > 1) begin : g_prod
         logic signed [PW-1:0] prod_q [LATENCY-1];
         always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
               for (int i = 0; i < LATENCY - 1; i++) prod_q[i] <= '0;
            end else begin
               prod_q[0] <= mul_c;
               for (int i = 1; i < LATENCY - 1; i++) prod_q[i] <= prod_q[i-1];
            end
         end
         assign prod_last = prod_q[LATENCY-2];
      end else begin : g_noreg
         assign prod_last = mul_c;
      end
   endgenerate

   assign shifted = prod_last >>> FRAC_BITS;

`ifdef MULT_SHARE_ARB_SAT_EN
   // in range only when all bits above the result sign bit match it
   always_comb begin
      out_data = shifted[DATA_WIDTH-1:0];
      if (!((&shifted[PW-1:DATA_WIDTH-1]) || !(|shifted[PW-1:DATA_WIDTH-1])))
         out_data = shifted[PW-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                  : {1'b0, {(DATA_WIDTH-1){1'b1}}};
   end
`else
   assign out_data = shifted[DATA_WIDTH-1:0];
`endif

   assign out_valid = vld_q[LATENCY-1];
   assign out_tag   = tag_q[LATENCY-1];

endmodule

// File: rtl/mult_share_arb.sv
// Round-robin arbiter sharing one pipelined multiplier among N_REQ requesters.
// Each requester has a valid/ready operand port and a held valid/ready result.
// A requester is blocked from a new grant while its transaction is in flight
// or its result is still held (busy).
// Optional: MULT_SHARE_ARB_SAT_EN saturates results instead of wrapping.
// Ports:
//   clock, reset                 clock, async active-high reset
//   req_valid/req_x/req_y        operand pairs (packed per requester)
//   req_ready                    one-hot grant
//   rsp_valid/rsp_data/rsp_ready held results and accept
//   busy                         transaction in flight or result held
import mult_share_arb_pkg::*;

module mult_share_arb #(
   parameter int N_REQ      = 4,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int LATENCY    = 3,
   parameter int FRAC_BITS  = BITS
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [N_REQ-1:0]            req_valid,
   input  logic [N_REQ*DATA_WIDTH-1:0] req_x,
   input  logic [N_REQ*DATA_WIDTH-1:0] req_y,
   output logic [N_REQ-1:0]            req_ready,
   output logic [N_REQ-1:0]            rsp_valid,
   output logic [N_REQ*DATA_WIDTH-1:0] rsp_data,
   input  logic [N_REQ-1:0]            rsp_ready,
   output logic [N_REQ-1:0]            busy
);

   logic [N_REQ-1:0]            busy_q, rsp_valid_q, eligible, grant;
   logic [N_REQ*DATA_WIDTH-1:0] rsp_data_q;
   tag_t                        rr_q, gnt_tag, wb_tag;
   logic                        gnt_any, wb_valid;
   logic [DATA_WIDTH-1:0]       wb_data;
   int                          arb_idx;

   assign eligible = req_valid & ~busy_q;

   always_comb begin
      grant   = '0;
      gnt_any = 1'b0;
      gnt_tag = '0;
      arb_idx = 0;
      for (int i = 0; i < N_REQ; i++) begin
         arb_idx = (int'(rr_q) + i) % N_REQ;
         if (!gnt_any && eligible[arb_idx]) begin
            grant[arb_idx] = 1'b1;
            gnt_any        = 1'b1;
            gnt_tag        = tag_t'(arb_idx);
         end
      end
   end

   mult_share_pipe #(
      .DATA_WIDTH (DATA_WIDTH),
      .LATENCY    (LATENCY),
      .FRAC_BITS  (FRAC_BITS)
   ) u_pipe (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (gnt_any),
      .in_tag    (gnt_tag),
      .in_x      (req_x[int'(gnt_tag)*DATA_WIDTH +: DATA_WIDTH]),
      .in_y      (req_y[int'(gnt_tag)*DATA_WIDTH +: DATA_WIDTH]),
      .out_valid (wb_valid),
      .out_tag   (wb_tag),
      .out_data  (wb_data)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rr_q        <= '0;
         busy_q      <= '0;
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
      end else begin
         if (gnt_any)
            rr_q <= (int'(gnt_tag) == N_REQ - 1) ? '0 : gnt_tag + tag_t'(1);
         for (int r = 0; r < N_REQ; r++) begin
            // grant and accept never coincide for one requester: busy gates the grant
            if (grant[r])
               busy_q[r] <= 1'b1;
            else if (rsp_valid_q[r] && rsp_ready[r])
               busy_q[r] <= 1'b0;
            if (wb_valid && wb_tag == tag_t'(r)) begin
               rsp_valid_q[r]                            <= 1'b1;
               rsp_data_q[r*DATA_WIDTH +: DATA_WIDTH]    <= wb_data;
            end else if (rsp_valid_q[r] && rsp_ready[r]) begin
               rsp_valid_q[r] <= 1'b0;
            end
         end
      end
   end

   // grant is combinational on req_valid, so mask it while reset is asserted
   assign req_ready = reset ? '0 : grant;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign busy      = busy_q;

endmodule

// File: doc/mult_share_arb.md
Name: mult_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one pipelined quantized multiplier among N_REQ requesters in the demod/stereo datapath.
- Typical requesters: the squaring stage on the pilot path, the pilot×L−R mixer and the demod cross-products.
- Replaces per-stage combinational multiply_n instances with one time-multiplexed DSP pipeline.
- Each requester gets a valid/ready request port and a held, valid/ready response register.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 32, signed operand/result width.
- LATENCY, 3, multiplier pipeline depth in cycles (≥1).
- FRAC_BITS, BITS from macros package (10), right-shift applied to the full product (dequantize).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  N_REQ  operand pair valid, per requester
- req_x  in  N_REQ*DATA_WIDTH  packed signed x operands, requester r at [r*DATA_WIDTH +: DATA_WIDTH]
- req_y  in  N_REQ*DATA_WIDTH  packed signed y operands, same packing
- req_ready  out  N_REQ  one-hot grant; an operand pair is consumed on a clock edge where req_valid[r]&req_ready[r]
- rsp_valid  out  N_REQ  result held for requester r
- rsp_data  out  N_REQ*DATA_WIDTH  packed held results
- rsp_ready  in  N_REQ  requester r accepts its result
- busy  out  N_REQ  request in flight or result held, per requester

Behaviour:
- Reset (async, active-high): req_ready=0; rsp_valid=0; rsp_data=0; busy=0; pipeline valid bits=0; rr pointer=0 (requester 0 highest priority).
- Eligibility: eligible[r] = req_valid[r] & ~busy[r], with busy taken from the register. At most one outstanding transaction per requester.
- Arbitration is combinational each cycle.
  - Search starts at the rr pointer and proceeds upward with wrap-around; the first eligible index is granted.
  - req_ready = that one-hot grant, or zero if nothing is eligible.
  - req_ready may depend combinationally on req_valid.
  - A requester holds x/y stable while req_valid is high until it is granted.
- On a grant edge:
  - capture x, y and tag=r into pipeline stage 1;
  - set busy[r];
  - set the rr pointer to r+1 mod N_REQ.
  - With no grant, the pointer holds.
- Pipeline: stages 1..LATENCY, each stage carrying valid and tag. There is no stall; each stage advances every cycle.
- Arithmetic:
  - product = signed(x) * signed(y), 2*DATA_WIDTH bits;
  - arithmetic shift right by FRAC_BITS;
  - result = low DATA_WIDTH bits (wrap).
- Writeback: on the edge where stage LATENCY is valid with tag t, rsp_data[t] is loaded and rsp_valid[t] is set.
  - Result is visible LATENCY cycles after the grant edge. With LATENCY=3, granted at edge k means rsp_valid high after edge k+3.
  - Writeback never collides with a held result, because busy blocks a re-grant.
- Response handshake: on an edge with rsp_valid[t]&rsp_ready[t], clear rsp_valid[t] and busy[t]. rsp_data[t] holds its value.
- Accept and re-request in the same cycle: busy is still set that cycle, so no grant. The earliest re-grant is the following cycle.
  - Maximum throughput per requester is therefore 1 result per LATENCY+2 cycles.
  - Aggregate throughput is 1 grant/cycle while ≥1 requester is eligible.
- rsp_ready with rsp_valid low: ignored.
- Reset mid-operation clears all in-flight and held results; those results are lost and are not emitted later.

Optional Feature:
- Macro MULT_SHARE_ARB_SAT_EN.
- Defined: the shifted product is saturated to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1] instead of wrapping. Saturation adds no latency; it happens in the final stage.
- Undefined: low DATA_WIDTH bits are taken (two's-complement wrap), matching multiply_n.

Decomposition:
- Shared package (macros): BITS, DATA_WIDTH default, tag typedef logic [$clog2(N_REQ)-1:0], and the saturation bound constants.
- Natural sub-module: mult_share_pipe.
  - Parameterized LATENCY pipelined signed multiply/shift/(sat) stage.
  - Carries valid+tag alongside the data.
  - Instantiated once.
- Arbiter, rr pointer, busy and response registers live in the top.

Test Plan:
- Basic product: N_REQ=4, LATENCY=3, BITS=10. Req0 x=2048 (2.0), y=1536 (1.5) → req_ready[0] same cycle; rsp_valid[0] 3 cycles after grant edge; rsp_data[0]=3072.
- Sign: req2 x=−1024, y=3072 → rsp_data[2]=−3072 (0xFFFFF400); busy[2] clears on the rsp_ready edge.
- Round-robin fairness: req0..3 valid continuously, rsp_ready all 1 → grants 0,1,2,3 on consecutive cycles.
  - Then each requester is re-granted only after its busy clears.
  - No requester is starved; grant order always wraps 0→3.
- Backpressure: rsp_ready[1]=0 while req1 keeps req_valid=1 → req1 never re-granted and rsp_data[1] stable; req0/2/3 continue to be granted. Raising rsp_ready[1] → busy[1] drops and req1 is re-granted the next cycle.
- Overflow: x=y=0x7FFFFFFF → rsp_data=0xFFC00000 without MULT_SHARE_ARB_SAT_EN; 0x7FFFFFFF with it defined.
- Async reset with 3 results in flight → all outputs 0 immediately. After release, no stale rsp_valid appears, and the first grant goes to requester 0.
